// File: rtl/fir_frame_packer.sv
// fir_frame_packer
//   Captures decimated channel A/B filter output pairs on the sample strobe,
//   buffers them in a small FIFO and serializes each frame as a byte stream:
//     START_BYTE, frame counter, then FRAME_LEN x {A[15:8],A[7:0],B[15:8],B[7:0]}
//   with each sample sign-extended to 16 bits.
//
// Ports
//   clk              system clock
//   rst_n            synchronous active-low reset
//   clk_2mhz_pos_en  decimated-rate strobe (one clk wide)
//   dvalid           filter output valid; sample strobe = dvalid & clk_2mhz_pos_en
//   din_a, din_b     signed channel A/B samples
//   start            single-cycle frame request (ignored while busy)
//   m_data, m_valid  registered output byte / valid
//   m_ready          downstream accepts byte
//   busy             frame in progress (capture or drain)
//   frame_done       one-cycle pulse after the last byte of a frame is accepted
//   overflow         sticky: a pair was dropped because the FIFO was full
module fir_frame_packer #(
  parameter int          DATA_WIDTH      = 14,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter int          FRAME_LEN       = 1024,
  parameter int          FRAME_LEN_LOG2  = 10,
  parameter logic [7:0]  START_BYTE      = 8'h5A
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_2mhz_pos_en,
  input  logic                  dvalid,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  start,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int EW = 2 * DATA_WIDTH;

  localparam logic       W_IDLE    = 1'b0;
  localparam logic       W_CAPTURE = 1'b1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_HDR  = 2'd1;
  localparam logic [1:0] R_CNT  = 2'd2;
  localparam logic [1:0] R_DATA = 2'd3;

  // FIFO storage and bookkeeping
  logic [EW-1:0]              mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [FIFO_DEPTH_LOG2:0]   fifo_cnt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_multi;
  logic [EW-1:0]              head_entry;
  logic [EW-1:0]              next_entry;

  // FSM state
  logic                       w_state;
  logic [1:0]                 r_state;
  logic [FRAME_LEN_LOG2:0]    wr_count;
  logic [FRAME_LEN_LOG2:0]    rd_count;
  logic [1:0]                 byte_idx;
  logic [1:0]                 byte_idx_nxt;
  logic [7:0]                 frame_cnt;

  // Handshake / control
  logic                       strobe;
  logic                       start_ok;
  logic                       wr_en;
  logic                       rd_en;
  logic                       accept;
  logic                       last_write;
  logic                       last_read;

  // Byte idx of a stored {A,B} entry, each sample sign-extended to 16 bits.
  function automatic logic [7:0] byte_of(input logic [EW-1:0] entry,
                                         input logic [1:0]    idx);
    logic [15:0] a16;
    logic [15:0] b16;
    a16 = 16'(signed'(entry[EW-1:DATA_WIDTH]));
    b16 = 16'(signed'(entry[DATA_WIDTH-1:0]));
    case (idx)
      2'd0:    byte_of = a16[15:8];
      2'd1:    byte_of = a16[7:0];
      2'd2:    byte_of = b16[15:8];
      default: byte_of = b16[7:0];
    endcase
  endfunction

  always_comb begin
    strobe       = dvalid && clk_2mhz_pos_en;
    fifo_full    = (fifo_cnt == (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH));
    fifo_empty   = (fifo_cnt == '0);
    fifo_multi   = (fifo_cnt > (FIFO_DEPTH_LOG2+1)'(1));
    rd_ptr_nxt   = rd_ptr + 1'b1;
    head_entry   = mem[rd_ptr];
    next_entry   = mem[rd_ptr_nxt];
    byte_idx_nxt = byte_idx + 2'd1;
    accept       = m_valid && m_ready;
    // Both FSMs idle: this includes the frame_done cycle, so a start there
    // chains the next frame directly.
    start_ok     = start && (w_state == W_IDLE) && (r_state == R_IDLE);
    rd_en        = (r_state == R_DATA) && accept && (byte_idx == 2'd3);
    // A pop in the same cycle frees a slot, so a write into a full FIFO succeeds.
    wr_en        = (w_state == W_CAPTURE) && strobe && (!fifo_full || rd_en);
    last_write   = (wr_count == (FRAME_LEN_LOG2+1)'(FRAME_LEN - 1));
    last_read    = (rd_count == (FRAME_LEN_LOG2+1)'(FRAME_LEN - 1));
    // frame_done is included so busy stays high across a chained start.
    busy         = (w_state != W_IDLE) || (r_state != R_IDLE) || frame_done;
  end

  // FIFO memory (no reset needed: pointers define what is valid)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {din_a, din_b};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Write (capture) FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (start_ok) begin
            w_state  <= W_CAPTURE;
            wr_count <= '0;
            overflow <= 1'b0;
          end
        end
        default: begin
          if (strobe) begin
            if (wr_en) begin
              wr_count <= wr_count + 1'b1;
              if (last_write) begin
                w_state <= W_IDLE;
              end
            end else begin
              overflow <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Read (serializer) FSM; m_data/m_valid are registered and only change
  // when the output slot is empty or its byte is being accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      m_data     <= '0;
      m_valid    <= 1'b0;
      byte_idx   <= '0;
      rd_count   <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (start_ok) begin
            r_state  <= R_HDR;
            m_valid  <= 1'b1;
            m_data   <= START_BYTE;
            byte_idx <= '0;
            rd_count <= '0;
          end
        end
        R_HDR: begin
          if (accept) begin
            r_state <= R_CNT;
            m_data  <= frame_cnt;
          end
        end
        R_CNT: begin
          if (accept) begin
            r_state  <= R_DATA;
            byte_idx <= '0;
            if (!fifo_empty) begin
              m_data <= byte_of(head_entry, 2'd0);
            end else begin
              m_valid <= 1'b0;
            end
          end
        end
        default: begin
          if (!m_valid) begin
            // Output slot empty: present the head entry once one exists.
            if (!fifo_empty) begin
              m_valid  <= 1'b1;
              m_data   <= byte_of(head_entry, 2'd0);
              byte_idx <= '0;
            end
          end else if (m_ready) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx_nxt;
              m_data   <= byte_of(head_entry, byte_idx_nxt);
            end else begin
              byte_idx <= '0;
              rd_count <= rd_count + 1'b1;
              if (last_read) begin
                r_state    <= R_IDLE;
                m_valid    <= 1'b0;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
              end else if (fifo_multi) begin
                // The head is popped this cycle; its successor is already stored.
                m_data <= byte_of(next_entry, 2'd0);
              end else begin
                m_valid <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_frame_packer.sv
`timescale 1ns/1ps
// Directed testbench for fir_frame_packer (FRAME_LEN reduced to 32 so the
// frame-counter wrap fits in a short run).
module tb_fir_frame_packer;

  localparam int FL = 32;
  localparam int NB = 2 + 4 * FL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_2mhz_pos_en = 1'b0;
  logic        dvalid = 1'b1;
  logic [13:0] din_a = '0;
  logic [13:0] din_b = '0;
  logic        start = 1'b0;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  fir_frame_packer #(
    .DATA_WIDTH(14),
    .FIFO_DEPTH(16),
    .FIFO_DEPTH_LOG2(4),
    .FRAME_LEN(FL),
    .FRAME_LEN_LOG2(5),
    .START_BYTE(8'h5A)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_2mhz_pos_en(clk_2mhz_pos_en),
    .dvalid(dvalid),
    .din_a(din_a),
    .din_b(din_b),
    .start(start),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow)
  );

  always #12 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Accepted-byte log, frame_done count and hold-stability monitor
  logic [7:0] rx[$];
  int         done_cnt = 0;
  int         hold_viol = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) rx.push_back(m_data);
      if (frame_done) done_cnt++;
      if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) hold_viol++;
    end
    pv = m_valid && rst_n;
    pr = m_ready;
    pd = m_data;
  end

  // Stimulus generator state
  int          period = 20;
  int          phase = 0;
  int          sent = 0;
  bit          strobe_on = 1'b0;
  bit          ramp_mode = 1'b0;
  bit          toggle_on = 1'b0;
  logic [13:0] ramp = '0;
  logic [13:0] ca = '0;
  logic [13:0] cb = '0;

  function automatic logic [15:0] ext16(input logic [13:0] v);
    return {{2{v[13]}}, v};
  endfunction

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    clk_2mhz_pos_en = 1'b0;
    if (strobe_on) begin
      if (phase >= period - 1) begin
        phase = 0;
        clk_2mhz_pos_en = 1'b1;
        if (ramp_mode) begin
          din_a = ramp;
          din_b = -ramp;
          ramp  = ramp + 14'd1;
        end else begin
          din_a = ca;
          din_b = cb;
        end
        sent++;
      end else begin
        phase++;
      end
    end
    if (toggle_on) m_ready = ~m_ready;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic begin_frame();
    rx.delete();
    start = 1'b1;
    phase = 0;
    sent = 0;
    strobe_on = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic wait_sent(input int target, output bit ok);
    int n = 0;
    while (sent < target && n < 2000) begin
      step();
      n++;
    end
    ok = (sent >= target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    steps(3);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got=%02h exp=00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_const_frame();
    bit ok;
    int base = done_cnt;
    logic [7:0] e [4];
    e[0] = 8'h1F; e[1] = 8'hFF; e[2] = 8'hFF; e[3] = 8'hFF;
    ca = 14'h1FFF; cb = 14'h3FFF; ramp_mode = 1'b0; period = 20; m_ready = 1'b1;
    begin_frame();
    wait_done(base + 1, FL * 20 + 300, ok);
    steps(5);
    strobe_on = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL const_timeout got=%0d exp=%0d frames", done_cnt - base, 1); end
    checks++; if (rx.size() != NB) begin errors++; $display("FAIL const_bytes got=%0d exp=%0d", rx.size(), NB); end
    checks++; if (rx[0] !== 8'h5A) begin errors++; $display("FAIL const_hdr0 got=%02h exp=5a", rx[0]); end
    checks++; if (rx[1] !== 8'h00) begin errors++; $display("FAIL const_hdr1 got=%02h exp=00", rx[1]); end
    for (int i = 2; i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== e[(i - 2) % 4]) begin
        errors++; $display("FAIL const_byte[%0d] got=%02h exp=%02h", i, rx[i], e[(i - 2) % 4]);
      end
    end
    checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL const_done_count got=%0d exp=1", done_cnt - base); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL const_overflow got=%0b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL const_busy_after got=%0b exp=0", busy); end
  endtask

  task automatic test_ramp_frame();
    bit ok;
    int base = done_cnt;
    logic [13:0] v;
    logic [13:0] nv;
    ramp = 14'h1FF0; ramp_mode = 1'b1; period = 20; m_ready = 1'b1;
    begin_frame();
    wait_done(base + 1, FL * 20 + 300, ok);
    strobe_on = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL ramp_timeout got=%0d exp=1 frames", done_cnt - base); end
    checks++; if (rx.size() != NB) begin errors++; $display("FAIL ramp_bytes got=%0d exp=%0d", rx.size(), NB); end
    checks++; if (rx[1] !== 8'h01) begin errors++; $display("FAIL ramp_hdr1 got=%02h exp=01", rx[1]); end
    for (int k = 0; k < FL && (2 + 4 * k + 3) < rx.size(); k++) begin
      v  = 14'h1FF0 + 14'(k);
      nv = -v;
      checks++;
      if ({rx[2+4*k], rx[3+4*k], rx[4+4*k], rx[5+4*k]} !== {ext16(v), ext16(nv)}) begin
        errors++;
        $display("FAIL ramp_pair[%0d] got=%02h%02h_%02h%02h exp=%04h_%04h", k,
                 rx[2+4*k], rx[3+4*k], rx[4+4*k], rx[5+4*k], ext16(v), ext16(nv));
      end
    end
  endtask

  task automatic test_stall_overflow();
    bit ok;
    int base = done_cnt;
    logic [13:0] v;
    logic [13:0] nv;
    ramp = 14'h0100; ramp_mode = 1'b1; period = 20; m_ready = 1'b1;
    hold_viol = 0;
    begin_frame();
    wait_sent(5, ok);
    steps(10);
    m_ready = 1'b0;
    steps(400);
    m_ready = 1'b1;
    wait_done(base + 1, FL * 40 + 800, ok);
    strobe_on = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=%0d exp=1 frames", done_cnt - base); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow got=%0b exp=1", overflow); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0 violations", hold_viol); end
    checks++; if (rx.size() != NB) begin errors++; $display("FAIL stall_bytes got=%0d exp=%0d", rx.size(), NB); end
    checks++; if (rx[1] !== 8'h02) begin errors++; $display("FAIL stall_hdr1 got=%02h exp=02", rx[1]); end
    // Pairs 0..20 are contiguous; strobes 21..24 of the ramp are dropped.
    for (int k = 0; k < FL && (2 + 4 * k + 3) < rx.size(); k++) begin
      v  = (k <= 20) ? 14'h0100 + 14'(k) : 14'h0100 + 14'(k + 4);
      nv = -v;
      checks++;
      if ({rx[2+4*k], rx[3+4*k], rx[4+4*k], rx[5+4*k]} !== {ext16(v), ext16(nv)}) begin
        errors++;
        $display("FAIL stall_pair[%0d] got=%02h%02h_%02h%02h exp=%04h_%04h", k,
                 rx[2+4*k], rx[3+4*k], rx[4+4*k], rx[5+4*k], ext16(v), ext16(nv));
      end
    end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    int base = done_cnt;
    logic [13:0] v;
    logic [13:0] nv;
    ramp = 14'h3FF8; ramp_mode = 1'b1; period = 20; m_ready = 1'b0;
    hold_viol = 0;
    toggle_on = 1'b1;
    begin_frame();
    wait_done(base + 1, FL * 20 + 400, ok);
    toggle_on = 1'b0; m_ready = 1'b1; strobe_on = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL toggle_timeout got=%0d exp=1 frames", done_cnt - base); end
    checks++; if (rx.size() != NB) begin errors++; $display("FAIL toggle_bytes got=%0d exp=%0d", rx.size(), NB); end
    checks++; if (rx[0] !== 8'h5A) begin errors++; $display("FAIL toggle_hdr0 got=%02h exp=5a", rx[0]); end
    checks++; if (rx[1] !== 8'h03) begin errors++; $display("FAIL toggle_hdr1 got=%02h exp=03", rx[1]); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL toggle_overflow_cleared got=%0b exp=0", overflow); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL toggle_hold got=%0d exp=0 violations", hold_viol); end
    for (int k = 0; k < FL && (2 + 4 * k + 3) < rx.size(); k++) begin
      v  = 14'h3FF8 + 14'(k);
      nv = -v;
      checks++;
      if ({rx[2+4*k], rx[3+4*k], rx[4+4*k], rx[5+4*k]} !== {ext16(v), ext16(nv)}) begin
        errors++;
        $display("FAIL toggle_pair[%0d] got=%02h%02h_%02h%02h exp=%04h_%04h", k,
                 rx[2+4*k], rx[3+4*k], rx[4+4*k], rx[5+4*k], ext16(v), ext16(nv));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int base;
    logic [7:0] e [4];
    e[0] = 8'h01; e[1] = 8'h23; e[2] = 8'hE4; e[3] = 8'h56;
    ramp = 14'h0200; ramp_mode = 1'b1; period = 20; m_ready = 1'b1;
    begin_frame();
    wait_sent(3, ok);
    m_ready = 1'b0;
    wait_sent(12, ok);
    rst_n = 1'b0;
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid got=%0b exp=0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    rst_n = 1'b1; strobe_on = 1'b0; m_ready = 1'b1;
    rx.delete();
    steps(20);
    checks++; if (rx.size() != 0) begin errors++; $display("FAIL rstmid_idle_bytes got=%0d exp=0", rx.size()); end
    base = done_cnt;
    ca = 14'h0123; cb = 14'h2456; ramp_mode = 1'b0;
    begin_frame();
    wait_done(base + 1, FL * 20 + 300, ok);
    strobe_on = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got=%0d exp=1 frames", done_cnt - base); end
    checks++; if (rx.size() != NB) begin errors++; $display("FAIL rstmid_bytes got=%0d exp=%0d", rx.size(), NB); end
    checks++; if (rx[0] !== 8'h5A) begin errors++; $display("FAIL rstmid_hdr0 got=%02h exp=5a", rx[0]); end
    checks++; if (rx[1] !== 8'h00) begin errors++; $display("FAIL rstmid_hdr1 got=%02h exp=00", rx[1]); end
    for (int i = 2; i < rx.size(); i++) begin
      checks++;
      if (rx[i] !== e[(i - 2) % 4]) begin
        errors++; $display("FAIL rstmid_byte[%0d] got=%02h exp=%02h", i, rx[i], e[(i - 2) % 4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base = done_cnt;
    int n = 0;
    int na;
    logic [7:0] hdr_a;
    ca = 14'h0AAA; cb = 14'h3000; ramp_mode = 1'b0; period = 20; m_ready = 1'b1;
    begin_frame();
    wait_sent(10, ok);
    // start pulses while busy must be ignored
    repeat (3) begin
      start = 1'b1; step(); start = 1'b0; step();
    end
    while (frame_done !== 1'b1 && n < FL * 20 + 300) begin
      step();
      n++;
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_wait_done got=%0b exp=1", frame_done); end
    start = 1'b1;
    na = rx.size();
    hdr_a = rx[1];
    rx.delete();
    phase = 0; sent = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_at_done got=%0b exp=1", busy); end
    step();
    start = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_next_valid got=%0b exp=1", m_valid); end
    checks++; if (m_data !== 8'h5A) begin errors++; $display("FAIL b2b_next_hdr got=%02h exp=5a", m_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_next got=%0b exp=1", busy); end
    wait_done(base + 2, FL * 20 + 300, ok);
    strobe_on = 1'b0;
    checks++; if (na != NB) begin errors++; $display("FAIL b2b_bytes_a got=%0d exp=%0d", na, NB); end
    checks++; if (hdr_a !== 8'h01) begin errors++; $display("FAIL b2b_hdr_a got=%02h exp=01", hdr_a); end
    checks++; if (rx.size() != NB) begin errors++; $display("FAIL b2b_bytes_b got=%0d exp=%0d", rx.size(), NB); end
    checks++; if (rx[1] !== 8'h02) begin errors++; $display("FAIL b2b_hdr_b got=%02h exp=02", rx[1]); end
    checks++; if (rx[2] !== 8'h0A || rx[4] !== 8'hF0) begin errors++; $display("FAIL b2b_data_b got=%02h,%02h exp=0a,f0", rx[2], rx[4]); end
    checks++; if (done_cnt != base + 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - base); end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    int base;
    rst_n = 1'b0; steps(2); rst_n = 1'b1; step();
    base = done_cnt;
    ca = 14'h0001; cb = 14'h0002; ramp_mode = 1'b0; period = 5; m_ready = 1'b1;
    for (int f = 0; f <= 256; f++) begin
      begin_frame();
      wait_done(base + f + 1, FL * 10 + 200, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL wrap_timeout got=%0d exp=%0d frames", done_cnt - base, f + 1);
        break;
      end
      if (f == 255) begin
        checks++; if (rx[1] !== 8'hFF) begin errors++; $display("FAIL wrap_hdr255 got=%02h exp=ff", rx[1]); end
      end
      if (f == 256) begin
        checks++; if (rx[1] !== 8'h00) begin errors++; $display("FAIL wrap_hdr256 got=%02h exp=00", rx[1]); end
        checks++; if (rx.size() != NB) begin errors++; $display("FAIL wrap_bytes got=%0d exp=%0d", rx.size(), NB); end
      end
    end
    strobe_on = 1'b0;
    checks++; if (done_cnt != base + 257) begin errors++; $display("FAIL wrap_frames got=%0d exp=257", done_cnt - base); end
  endtask

  initial begin
    test_reset();
    test_const_frame();
    test_ramp_frame();
    test_stall_overflow();
    test_ready_toggle();
    test_reset_mid_frame();
    test_back_to_back();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
